uart_matrix_loader: RTL and testbench
=====================================

Name: uart_matrix_loader

Overview:
Consumes completed UART frames from the receiver (`rx_status` busy flag plus 10-bit frame) and turns them into a sequenced stream of element writes for the matrix multiplier's operand store. It fills matrix A first, then matrix B, each N×N elements of 8 bits, row-major. It validates framing, counts bad frames, and signals load completion with a done/ack handshake. It sits between the receiver and the operand register file / multiply FSM.

Parameters:
- N, 2, matrix dimension; the block loads 2·N·N elements in total.
- ADDR_W, 3, width of `wr_addr`; must satisfy 2^ADDR_W ≥ 2·N·N.
- ERR_W, 4, width of the saturating frame-error counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-low reset.
- rx_status  in  1  receiver busy flag; 1 while a frame is being received, falls when the frame is complete.
- rx_frame  in  10  received frame: [0]=start bit, [8:1]=data LSB-first, [9]=stop bit; stable while rx_status=0.
- load_ack  in  1  consumer acknowledge of `load_done`.
- wr_en  out  1  one-cycle element write strobe.
- wr_addr  out  ADDR_W  element index 0..2N²-1; A occupies 0..N²-1, B occupies N²..2N²-1.
- wr_data  out  8  element value.
- mat_sel  out  1  0 = element belongs to A, 1 = element belongs to B.
- load_done  out  1  level; both matrices fully loaded.
- busy  out  1  high from the first valid write until `load_done`.
- err_count  out  ERR_W  count of rejected frames, saturating.

Behaviour:
- Reset (`rst`=0 at a clk edge):
  - All outputs go to 0.
  - Element index = 0, state = LOAD.
  - Synchroniser flops s1, s2, s3 = 0.
  - Frame latch `frame_q` = 0.
  - Reset mid-load discards the partial load and clears `err_count`.
- Input sync:
  - `rx_status` passes through a 2-flop synchroniser (s1, s2) plus a history flop s3.
  - `frame_end` = s3 & ~s2 (falling edge). With s* reset to 0, `rx_status` held low out of reset never produces `frame_end`.
- States:
  - LOAD:
    - On `frame_end`, latch `rx_frame` into `frame_q` and go to CHECK. Otherwise stay.
  - CHECK (exactly 1 cycle):
    - Valid frame (`frame_q[0]`=0 and `frame_q[9]`=1): on the next edge register `wr_en`=1, `wr_addr`=index, `wr_data`=`frame_q[8:1]`, `mat_sel`=(index ≥ N²), `busy`=1.
      - If index = 2N²-1, go to DONE. Otherwise index+1 and go to LOAD.
    - Invalid frame: no write, `err_count` += 1 saturating at 2^ERR_W-1, index unchanged, go to LOAD.
  - DONE:
    - `load_done`=1 from the edge after the last `wr_en` cycle; `busy`=0.
    - Frames arriving in DONE are ignored: no write, no error count.
    - `load_ack`=1 sampled in DONE: next edge `load_done`=0, index=0, go to LOAD.
- Write strobe:
  - `wr_en` is high for exactly one cycle per valid frame and is 0 in all other cycles.
  - `wr_addr`, `wr_data` and `mat_sel` hold their last values when `wr_en`=0.
- Latency: with E0 = the first clk edge sampling `rx_status`=0, `frame_end` is true after E1, the frame is latched at E2, and `wr_en` is high after E3 until E4.
- Handshake:
  - `load_ack` outside DONE is ignored.
  - `load_ack` held high continuously releases DONE after one cycle.
- Back-to-back frames: the receiver's minimum frame spacing far exceeds the 3-cycle LOAD→CHECK→LOAD turnaround. Every `frame_end` that occurs in LOAD is processed; none are lost.
- Unused states decode to LOAD.

Test Plan:
1. Reset: hold `rst`=0 for 3 cycles with `rx_status` toggling → all outputs 0; no `wr_en` for 5 cycles after release with `rx_status`=0.
2. Full load, N=2: send 8 valid frames with data 0x01..0x08 (`rx_frame` = {1, data, 0}).
   - Expect 8 single-cycle `wr_en` pulses, `wr_addr` 0..7, `wr_data` 0x01..0x08.
   - Expect `mat_sel`=0 for addr 0–3 and 1 for addr 4–7.
   - Each `wr_en` occurs 3 edges after E0.
   - `load_done`=1 the cycle after the 8th pulse, `busy`=0.
3. Framing error: after 2 valid frames send `rx_frame`=10'h0FE (stop=0), then one with start=1 → no `wr_en` for either, `err_count`=2; the next valid frame writes addr 2.
4. DONE/ack: after a full load send a valid frame → no `wr_en`, `err_count` unchanged. Pulse `load_ack` for 1 cycle → `load_done`=0 next cycle; the next frame 0xAA writes addr 0 with `mat_sel`=0.
5. Reset mid-load: after 3 valid frames and 1 bad frame, pulse `rst`=0 → `err_count`=0, `busy`=0; the next frame writes addr 0.
6. Saturation: send 17 invalid frames with ERR_W=4 → `err_count` stops at 15, no `wr_en` ever asserted.

Source files
------------

// File: rtl/uart_matrix_loader.sv
// Turns completed UART frames into a row-major stream of element writes,
// filling matrix A and then matrix B, with framing checks and a done/ack handshake.
module uart_matrix_loader #(
    parameter int N      = 2,
    parameter int ADDR_W = 3,
    parameter int ERR_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_status,
    input  logic [9:0]        rx_frame,
    input  logic              load_ack,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              mat_sel,
    output logic              load_done,
    output logic              busy,
    output logic [ERR_W-1:0]  err_count
);

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_CHECK = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] B_BASE  = ADDR_W'(N * N);
    localparam logic [ADDR_W-1:0] LAST_IX = ADDR_W'(2 * N * N - 1);
    localparam logic [ERR_W-1:0]  ERR_MAX = {ERR_W{1'b1}};

    // A frame is well formed when the start bit is low and the stop bit is high.
    function automatic logic frame_ok(input logic [9:0] f);
        return (f[0] == 1'b0) && (f[9] == 1'b1);
    endfunction

    state_t              state_r;
    logic [ADDR_W-1:0]   index_r;
    logic [9:0]          frame_q_r;
    logic                s1_r, s2_r, s3_r;
    logic                frame_end_s;
    logic                frame_valid_s;
    logic                wr_en_r;
    logic [ADDR_W-1:0]   wr_addr_r;
    logic [7:0]          wr_data_r;
    logic                mat_sel_r;
    logic                load_done_r;
    logic                busy_r;
    logic [ERR_W-1:0]    err_count_r;

    // Falling edge of the synchronised busy flag marks a completed frame.
    always_comb begin
        frame_end_s   = s3_r & ~s2_r;
        frame_valid_s = frame_ok(frame_q_r);
    end

    // Two-flop synchroniser for rx_status plus a history flop for edge detection.
    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_r <= 1'b0;
            s2_r <= 1'b0;
            s3_r <= 1'b0;
        end else begin
            s1_r <= rx_status;
            s2_r <= s1_r;
            s3_r <= s2_r;
        end
    end

    // Load sequencer: latch frame, validate, emit one write, track completion.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r     <= ST_LOAD;
            index_r     <= {ADDR_W{1'b0}};
            frame_q_r   <= 10'd0;
            wr_en_r     <= 1'b0;
            wr_addr_r   <= {ADDR_W{1'b0}};
            wr_data_r   <= 8'd0;
            mat_sel_r   <= 1'b0;
            load_done_r <= 1'b0;
            busy_r      <= 1'b0;
            err_count_r <= {ERR_W{1'b0}};
        end else begin
            wr_en_r <= 1'b0;
            case (state_r)
                ST_LOAD: begin
                    if (frame_end_s) begin
                        frame_q_r <= rx_frame;
                        state_r   <= ST_CHECK;
                    end else begin
                        state_r   <= ST_LOAD;
                    end
                end
                ST_CHECK: begin
                    if (frame_valid_s) begin
                        wr_en_r   <= 1'b1;
                        wr_addr_r <= index_r;
                        wr_data_r <= frame_q_r[8:1];
                        mat_sel_r <= (index_r >= B_BASE);
                        busy_r    <= 1'b1;
                        if (index_r == LAST_IX) begin
                            state_r <= ST_DONE;
                        end else begin
                            index_r <= index_r + {{(ADDR_W-1){1'b0}}, 1'b1};
                            state_r <= ST_LOAD;
                        end
                    end else begin
                        if (err_count_r != ERR_MAX) begin
                            err_count_r <= err_count_r + {{(ERR_W-1){1'b0}}, 1'b1};
                        end else begin
                            err_count_r <= err_count_r;
                        end
                        state_r <= ST_LOAD;
                    end
                end
                ST_DONE: begin
                    // load_done must be visible for at least one cycle before an ack can release it.
                    busy_r <= 1'b0;
                    if (load_done_r && load_ack) begin
                        load_done_r <= 1'b0;
                        index_r     <= {ADDR_W{1'b0}};
                        state_r     <= ST_LOAD;
                    end else begin
                        load_done_r <= 1'b1;
                        state_r     <= ST_DONE;
                    end
                end
                default: begin
                    state_r <= ST_LOAD;
                end
            endcase
        end
    end

    assign wr_en     = wr_en_r;
    assign wr_addr   = wr_addr_r;
    assign wr_data   = wr_data_r;
    assign mat_sel   = mat_sel_r;
    assign load_done = load_done_r;
    assign busy      = busy_r;
    assign err_count = err_count_r;

endmodule

// File: tb/tb_uart_matrix_loader.sv
// Directed, table-driven bench for uart_matrix_loader (N=2, ADDR_W=3, ERR_W=4).
module tb_uart_matrix_loader;

    logic       clk;
    logic       rst;
    logic       rx_status;
    logic [9:0] rx_frame;
    logic       load_ack;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [7:0] wr_data;
    logic       mat_sel;
    logic       load_done;
    logic       busy;
    logic [3:0] err_count;

    int checks;
    int failures;

    uart_matrix_loader #(.N(2), .ADDR_W(3), .ERR_W(4)) dut (
        .clk(clk), .rst(rst), .rx_status(rx_status), .rx_frame(rx_frame),
        .load_ack(load_ack), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .mat_sel(mat_sel), .load_done(load_done), .busy(busy), .err_count(err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [9:0] frame;
        logic       exp_we;
        logic [2:0] exp_addr;
        logic [7:0] exp_data;
        logic       exp_sel;
        logic [3:0] exp_err;
        logic       exp_busy;
        logic       exp_done;
    } vec_t;

    vec_t vecs [11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [9:0] good(input logic [7:0] d);
        return {1'b1, d, 1'b0};
    endfunction

    // Send one frame and check the write (3 edges after E0) plus status afterwards.
    task automatic send(input logic [9:0] frame, input logic exp_we, input logic [2:0] exp_addr,
                        input logic [7:0] exp_data, input logic exp_sel, input logic [3:0] exp_err,
                        input logic exp_busy, input logic exp_done);
        rx_status = 1'b1;
        repeat (4) @(negedge clk);
        rx_frame  = frame;
        rx_status = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            check($sformatf("wr_en@%0d", k), wr_en, (k == 4) ? exp_we : 1'b0);
            if (k == 4 && exp_we) begin
                check("wr_addr", wr_addr, exp_addr);
                check("wr_data", wr_data, exp_data);
                check("mat_sel", mat_sel, exp_sel);
            end
            if (k == 5) check("load_done", load_done, exp_done);
        end
        check("err_count", err_count, exp_err);
        check("busy", busy, exp_busy);
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst       = 1'b0;
        rx_status = 1'b0;
        rx_frame  = 10'd0;
        load_ack  = 1'b0;

        vecs[0]  = '{good(8'h01), 1'b1, 3'd0, 8'h01, 1'b0, 4'd0, 1'b1, 1'b0};
        vecs[1]  = '{good(8'h02), 1'b1, 3'd1, 8'h02, 1'b0, 4'd0, 1'b1, 1'b0};
        vecs[2]  = '{10'h0FE,     1'b0, 3'd0, 8'h00, 1'b0, 4'd1, 1'b1, 1'b0};
        vecs[3]  = '{10'h203,     1'b0, 3'd0, 8'h00, 1'b0, 4'd2, 1'b1, 1'b0};
        vecs[4]  = '{good(8'h03), 1'b1, 3'd2, 8'h03, 1'b0, 4'd2, 1'b1, 1'b0};
        vecs[5]  = '{good(8'h04), 1'b1, 3'd3, 8'h04, 1'b0, 4'd2, 1'b1, 1'b0};
        vecs[6]  = '{good(8'h05), 1'b1, 3'd4, 8'h05, 1'b1, 4'd2, 1'b1, 1'b0};
        vecs[7]  = '{good(8'h06), 1'b1, 3'd5, 8'h06, 1'b1, 4'd2, 1'b1, 1'b0};
        vecs[8]  = '{good(8'h07), 1'b1, 3'd6, 8'h07, 1'b1, 4'd2, 1'b1, 1'b0};
        vecs[9]  = '{good(8'h08), 1'b1, 3'd7, 8'h08, 1'b1, 4'd2, 1'b0, 1'b1};
        vecs[10] = '{good(8'h55), 1'b0, 3'd0, 8'h00, 1'b0, 4'd2, 1'b0, 1'b1};

        // Reset held with rx_status toggling
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            rx_status = ~rx_status;
        end
        @(negedge clk);
        check("rst wr_en", wr_en, 1'b0);
        check("rst wr_addr", wr_addr, 3'd0);
        check("rst wr_data", wr_data, 8'd0);
        check("rst mat_sel", mat_sel, 1'b0);
        check("rst load_done", load_done, 1'b0);
        check("rst busy", busy, 1'b0);
        check("rst err_count", err_count, 4'd0);
        rst       = 1'b1;
        rx_status = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("idle wr_en", wr_en, 1'b0);
        end

        // Full load with framing errors interleaved, then a frame in DONE
        for (int i = 0; i < 11; i++) begin
            send(vecs[i].frame, vecs[i].exp_we, vecs[i].exp_addr, vecs[i].exp_data,
                 vecs[i].exp_sel, vecs[i].exp_err, vecs[i].exp_busy, vecs[i].exp_done);
        end

        // One-cycle ack releases DONE
        load_ack = 1'b1;
        @(negedge clk);
        load_ack = 1'b0;
        check("ack load_done", load_done, 1'b0);
        send(good(8'hAA), 1'b1, 3'd0, 8'hAA, 1'b0, 4'd2, 1'b1, 1'b0);

        // Ack outside DONE is ignored
        load_ack = 1'b1;
        repeat (2) @(negedge clk);
        load_ack = 1'b0;
        send(good(8'h11), 1'b1, 3'd1, 8'h11, 1'b0, 4'd2, 1'b1, 1'b0);
        send(good(8'h22), 1'b1, 3'd2, 8'h22, 1'b0, 4'd2, 1'b1, 1'b0);
        send(10'h0FE,     1'b0, 3'd0, 8'h00, 1'b0, 4'd3, 1'b1, 1'b0);

        // Reset mid-load discards the partial load
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check("mid rst err_count", err_count, 4'd0);
        check("mid rst busy", busy, 1'b0);
        check("mid rst wr_addr", wr_addr, 3'd0);
        send(good(8'h33), 1'b1, 3'd0, 8'h33, 1'b0, 4'd0, 1'b1, 1'b0);

        // Error counter saturation
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 1; i <= 17; i++) begin
            send(10'h0FE, 1'b0, 3'd0, 8'h00, 1'b0, (i > 15) ? 4'd15 : 4'(i), 1'b0, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
